// File: rtl/fpu_pkg.sv
// Shared FPU definitions: result status encoding and packed-float field widths.
// Used by the FPU datapath and by fp_int_encoder.
package fpu_pkg;

   typedef enum logic [1:0] {
      EXACT     = 2'd0,
      INEXACT   = 2'd1,
      OVERFLOW  = 2'd2,
      UNDERFLOW = 2'd3
   } status_t;

   localparam int EXP_W    = 10;
   localparam int FRAC_W   = 21;
   localparam int EXP_BIAS = 511;

endpackage

// File: rtl/fp_enc_round.sv
// Combinational pack stage of fp_int_encoder: turns a normalized magnitude,
// its shift count and the sign into a packed float plus an inexact flag.
// Build option FP_ENC_ROUND_EN: round to nearest-even instead of truncating.
module fp_enc_round
   import fpu_pkg::*;
(
   input  logic [31:0] mag_i,
   input  logic [4:0]  count_i,
   input  logic        sign_i,
   output logic [31:0] word_o,
   output logic        inexact_o
);

   logic [EXP_W-1:0]  exp_w;
   logic [FRAC_W-1:0] frac_w;
`ifdef FP_ENC_ROUND_EN
   logic              guard;
   logic              sticky;
   logic              frac_carry;
`endif

   // Exponent from shift count, fraction below the hidden 1, optional RNE rounding.
   always_comb begin
      exp_w     = EXP_W'(EXP_BIAS + 31) - EXP_W'(count_i);
      frac_w    = mag_i[30:10];
      inexact_o = |mag_i[9:0];
`ifdef FP_ENC_ROUND_EN
      guard      = mag_i[9];
      sticky     = |mag_i[8:0];
      frac_carry = 1'b0;
      if (guard & (sticky | frac_w[0])) begin
         // A carry out of the fraction leaves it zero and bumps the exponent.
         {frac_carry, frac_w} = {1'b0, mag_i[30:10]} + 22'd1;
      end
      if (frac_carry) begin
         exp_w = exp_w + EXP_W'(1);
      end
`endif
      if (mag_i == 32'd0) begin
         word_o    = 32'd0;
         inexact_o = 1'b0;
      end else begin
         word_o = {sign_i, exp_w, frac_w};
      end
   end

endmodule

// File: rtl/fp_int_encoder.sv
// Serial int32 -> packed float encoder. Normalizes one bit per cycle, then
// packs through fp_enc_round. Valid/ready handshakes on both sides.
// Build option FP_ENC_ROUND_EN (in fp_enc_round): round to nearest-even.
module fp_int_encoder
   import fpu_pkg::*;
(
   input  logic        clock_100Khz,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] int_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] data_out,
   output status_t     status_out
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      NORMALIZE = 3'd2,
      PACK      = 3'd3,
      DONE      = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic signed [31:0] operand_q, operand_d;
   logic               sign_q, sign_d;
   logic [31:0]        mag_q, mag_d;
   logic [4:0]         count_q, count_d;
   logic               out_valid_q, out_valid_d;
   logic [31:0]        data_q, data_d;
   status_t            status_q, status_d;

   logic [31:0]        packed_word;
   logic               pack_inexact;

   fp_enc_round u_round (
      .mag_i     (mag_q),
      .count_i   (count_q),
      .sign_i    (sign_q),
      .word_o    (packed_word),
      .inexact_o (pack_inexact)
   );

   // Next-state and datapath updates for the encode sequence.
   always_comb begin
      state_d     = state_q;
      operand_d   = operand_q;
      sign_d      = sign_q;
      mag_d       = mag_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      data_d      = data_q;
      status_d    = status_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               operand_d = int_in;
               state_d   = LOAD;
            end
         end
         LOAD: begin
            // Negating -2^31 wraps to 0x80000000, which is the correct magnitude.
            sign_d  = operand_q[31];
            mag_d   = operand_q[31] ? $unsigned(-operand_q) : $unsigned(operand_q);
            count_d = 5'd0;
            state_d = (operand_q == 32'sd0) ? PACK : NORMALIZE;
         end
         NORMALIZE: begin
            if (mag_q[31]) begin
               state_d = PACK;
            end else begin
               mag_d   = mag_q << 1;
               count_d = count_q + 5'd1;
            end
         end
         PACK: begin
            data_d      = packed_word;
            status_d    = pack_inexact ? INEXACT : EXACT;
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers; reset discards any operation in flight.
   always_ff @(posedge clock_100Khz) begin
      if (reset) begin
         state_q     <= IDLE;
         sign_q      <= 1'b0;
         mag_q       <= 32'd0;
         count_q     <= 5'd0;
         out_valid_q <= 1'b0;
         data_q      <= 32'd0;
         status_q    <= EXACT;
      end else begin
         state_q     <= state_d;
         sign_q      <= sign_d;
         mag_q       <= mag_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         data_q      <= data_d;
         status_q    <= status_d;
      end
   end

   // Captured operand is only consumed in LOAD, so it needs no reset.
   always_ff @(posedge clock_100Khz) begin
      operand_q <= operand_d;
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = out_valid_q;
   assign data_out   = data_q;
   assign status_out = status_q;

endmodule

// File: tb/tb_fp_int_encoder.sv
// Scoreboard bench for fp_int_encoder: directed operands with hand-computed
// packed results, status and output latency.
`timescale 1ns/1ps
module tb_fp_int_encoder;
   import fpu_pkg::*;

   logic        clock_100Khz = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] int_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] data_out;
   status_t     status_out;

   fp_int_encoder dut (
      .clock_100Khz (clock_100Khz),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .int_in       (int_in),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .data_out     (data_out),
      .status_out   (status_out)
   );

   always #5 clock_100Khz = ~clock_100Khz;

   int cyc = 0;
   always @(posedge clock_100Khz) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] din;
      logic [31:0] data;
      status_t     st;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   nchk  = 0;
   int   npass = 0;

   task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
      nchk++;
      if (ok) npass++;
      else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
   endtask

   // Monitor: pop and compare on each rising out_valid.
   exp_t mon_e;
   logic prev_v = 1'b0;
   always @(negedge clock_100Khz) begin
      if (out_valid && !prev_v) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", 1'b0, data_out, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check($sformatf("data[%08h]", mon_e.din), data_out === mon_e.data, data_out, mon_e.data);
            check($sformatf("status[%08h]", mon_e.din), status_out === mon_e.st,
                  32'(status_out), 32'(mon_e.st));
            check($sformatf("latency[%08h]", mon_e.din), (cyc - mon_e.acc) == mon_e.lat,
                  32'(cyc - mon_e.acc), 32'(mon_e.lat));
         end
      end
      prev_v = out_valid;
   end

   // Present one operand from a negedge, push its expectation at the accepting edge.
   task automatic issue(input logic [31:0] v, input logic [31:0] d, input status_t s, input int lat);
      exp_t e;
      int   n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clock_100Khz);
         n++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 1'b0, 32'(in_ready), 32'd1);
         return;
      end
      in_valid = 1'b1;
      int_in   = v;
      @(posedge clock_100Khz);
      #1;
      e.din  = v;
      e.data = d;
      e.st   = s;
      e.lat  = lat;
      e.acc  = cyc;
      sb.push_back(e);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clock_100Khz);
         n++;
      end while (!in_ready && n < 100);
      if (!in_ready) check("idle_timeout", 1'b0, 32'(in_ready), 32'd1);
   endtask

   task automatic send(input logic [31:0] v, input logic [31:0] d, input status_t s, input int lat);
      issue(v, d, s, lat);
      wait_idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [31:0] hd;
   status_t     hs;
   bit          stable, rdy_low, sawv;

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      int_in    = 32'd0;
      repeat (3) @(posedge clock_100Khz);
      @(negedge clock_100Khz);
      check("rst_data_out", data_out === 32'd0, data_out, 32'd0);
      check("rst_out_valid", out_valid === 1'b0, 32'(out_valid), 32'd0);
      check("rst_status", status_out === EXACT, 32'(status_out), 32'(EXACT));
      check("rst_in_ready", in_ready === 1'b1, 32'(in_ready), 32'd1);
      reset = 1'b0;

      send(32'h0000_0001, 32'h3FE0_0000, EXACT, 34);
      send(32'hFFFF_FFFF, 32'hBFE0_0000, EXACT, 34);
      send(32'h0000_0003, 32'h4010_0000, EXACT, 33);
      send(32'h8000_0000, 32'hC3C0_0000, EXACT, 3);
      send(32'h0000_0000, 32'h0000_0000, EXACT, 2);
`ifdef FP_ENC_ROUND_EN
      send(32'h7FFF_FFFF, 32'h43C0_0000, INEXACT, 4);
      send(32'h00FF_FFFF, 32'h42E0_0000, INEXACT, 11);
`else
      send(32'h7FFF_FFFF, 32'h43BF_FFFF, INEXACT, 4);
      send(32'h00FF_FFFF, 32'h42DF_FFFF, INEXACT, 11);
`endif
      send(32'hFFFF_FFFE, 32'hC000_0000, EXACT, 33);
      send(32'h0000_0401, 32'h4120_0800, EXACT, 24);
      send(32'h0020_0001, 32'h4280_0001, EXACT, 13);
      send(32'h4000_0100, 32'h43A0_0000, INEXACT, 4);

      // Back-pressure: result must hold and new operands must be ignored.
      out_ready = 1'b0;
      issue(32'h0000_0001, 32'h3FE0_0000, EXACT, 34);
      begin
         int n = 0;
         while (!out_valid && n < 60) begin
            @(negedge clock_100Khz);
            n++;
         end
      end
      check("hold_out_valid_rise", out_valid === 1'b1, 32'(out_valid), 32'd1);
      hd      = data_out;
      hs      = status_out;
      stable  = 1'b1;
      rdy_low = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         int_in   = 32'h0000_1234 + 32'(i);
         @(negedge clock_100Khz);
         stable  &= (out_valid === 1'b1) && (data_out === hd) && (status_out === hs);
         rdy_low &= (in_ready === 1'b0);
      end
      in_valid = 1'b0;
      check("hold_outputs_stable", stable, data_out, hd);
      check("hold_in_ready_low", rdy_low, 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(negedge clock_100Khz);
      check("release_out_valid", out_valid === 1'b0, 32'(out_valid), 32'd0);
      check("release_in_ready", in_ready === 1'b1, 32'(in_ready), 32'd1);

      // Reset during NORMALIZE discards the operation.
      in_valid = 1'b1;
      int_in   = 32'h0000_0001;
      @(posedge clock_100Khz);
      #1;
      in_valid = 1'b0;
      repeat (10) @(negedge clock_100Khz);
      reset = 1'b1;
      @(negedge clock_100Khz);
      reset = 1'b0;
      sawv  = 1'b0;
      repeat (40) begin
         @(negedge clock_100Khz);
         sawv |= out_valid;
      end
      check("abort_no_out_valid", !sawv, 32'(sawv), 32'd0);
      check("abort_in_ready", in_ready === 1'b1, 32'(in_ready), 32'd1);
      check("abort_data_out", data_out === 32'd0, data_out, 32'd0);
      check("abort_status", status_out === EXACT, 32'(status_out), 32'(EXACT));

      repeat (5) @(negedge clock_100Khz);
      check("scoreboard_drained", sb.size() == 0, 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/fp_int_encoder.md
FP_INT_ENCODER -- requirements
Module: fp_int_encoder

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 clock_100Khz  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  int_in is valid.
REQ-005 in_ready  output  1  encoder is idle and can accept an operand.
REQ-006 int_in  input  32  two's-complement signed integer.
REQ-007 out_valid  output  1  data_out and status_out are valid.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 data_out  output  32  packed float: sign [31], biased exponent [30:21], fraction [20:0] with hidden 1.
REQ-010 status_out  output  status_t  OVERFLOW, UNDERFLOW, EXACT or INEXACT.

Function
REQ-011 The FSM SHALL have states IDLE, LOAD, NORMALIZE, PACK and DONE; in_ready = (state == IDLE).
REQ-012 In IDLE, in_valid & in_ready SHALL capture int_in and go to LOAD.
REQ-013 LOAD SHALL register the sign and the 32-bit unsigned magnitude (0x80000000 for -2^31), and set shift count = 0.
REQ-014 LOAD SHALL go to PACK for a zero operand; otherwise it SHALL go to NORMALIZE.
REQ-015 NORMALIZE SHALL check magnitude bit 31 each cycle: if 0, shift left by 1 and increment count; if 1, go to PACK (one bit per cycle, no barrel shifter).
REQ-016 PACK SHALL produce the fields below, set out_valid = 1 and go to DONE:
- exponent = 511 + (31 - count);
- fraction = magnitude[30:10];
- sign = captured sign.
REQ-017 A zero operand SHALL produce data_out = 0x00000000 with status EXACT.
REQ-018 status_out SHALL be INEXACT if magnitude[9:0] != 0 or the fraction was rounded up, else EXACT.
REQ-019 OVERFLOW and UNDERFLOW SHALL never be produced; the maximum exponent is 542.
REQ-020 With MSB position p (31 - p shifts), out_valid SHALL rise (34 - p) cycles after the accepting edge; zero SHALL take 2 cycles.
REQ-021 In DONE, data_out, status_out and out_valid SHALL hold stable while out_ready = 0.
REQ-022 out_valid & out_ready SHALL return the FSM to IDLE, with out_valid = 0 and in_ready = 1 on the next cycle.
REQ-023 in_valid asserted outside IDLE SHALL be ignored; there is no operand queue.

Reset
REQ-024 While reset = 1 the block SHALL force: state IDLE, out_valid 0, data_out 0, status_out EXACT, sign 0, magnitude 0, count 0.
REQ-025 reset asserted mid-operation (any state) SHALL discard the operation; no result is emitted.

Configuration
REQ-026 When FP_ENC_ROUND_EN is defined, PACK SHALL round to nearest-even:
- guard = magnitude[9], sticky = |magnitude[8:0];
- increment the fraction when guard & (sticky | fraction[0]);
- a fraction carry-out SHALL zero the fraction and increment the exponent.
REQ-027 When FP_ENC_ROUND_EN is undefined, PACK SHALL truncate (no increment), matching the FPU's truncating datapath.

Structure
REQ-028 The shared package fpu_pkg SHALL hold the following; the FPU and this block SHALL both import it:
- status_t;
- widths EXP_W = 10, FRAC_W = 21;
- EXP_BIAS = 511.
REQ-029 The block-local state enum SHALL stay inside fp_int_encoder.
REQ-030 Rounding/packing SHALL live in one combinational sub-module, fp_enc_round (inputs: normalized magnitude, count, sign; outputs: packed word and inexact flag).

Verification
REQ-031 int_in = 1 -> data_out 0x3FE00000, status EXACT, out_valid 34 cycles after accept.
REQ-032 int_in = 0xFFFFFFFF (-1) -> 0xBFE00000 EXACT; int_in = 3 -> 0x40100000 EXACT after 33 cycles.
REQ-033 int_in = 0x80000000 -> 0xC3C00000 EXACT after 3 cycles; int_in = 0 -> 0x00000000 EXACT after 2 cycles.
REQ-034 int_in = 0x7FFFFFFF:
- without the macro -> 0x43BFFFFF INEXACT;
- with FP_ENC_ROUND_EN -> 0x43C00000 INEXACT.
REQ-035 Hold out_ready = 0 for 10 cycles after out_valid -> outputs stable, in_ready stays 0, extra in_valid pulses ignored; then out_ready = 1 -> in_ready = 1 next cycle.
REQ-036 Assert reset for 1 cycle during NORMALIZE of int_in = 1 -> out_valid never rises, state IDLE, data_out 0, status EXACT.
